// File: rtl/conv2_bias_add.sv
// conv2_bias_add
//   Per-channel bias adder for the conv2 output stream.
//   After reset or clr the block sits in LOAD and captures CH_NUM bias words,
//   channel 0 first, one per b_en strobe. It then moves to RUN and accepts
//   signed partial sums with a valid/ready handshake. Each partial sum gets the
//   bias of its channel added, is saturated to DATA_WIDTH bits and, when
//   RELU_EN is set, is clamped at zero. The result is registered and appears
//   one cycle after acceptance.
//
// Ports
//   clk, rst        clock (rising edge), asynchronous active-high reset
//   clr             synchronous clear: drop the bias table and return to LOAD
//   b_en, b_in      bias word strobe and signed bias word (LOAD only)
//   d_valid/d_ready partial-sum handshake; d_in is the sum, d_ch its channel
//   q_valid/q_ready result handshake; q_data is the result, q_ch its channel
//   bias_loaded     high while in RUN
//   ch_err          sticky: a partial sum with d_ch >= CH_NUM was accepted
module conv2_bias_add #(
  parameter int BIAS_WIDTH = 8,
  parameter int DATA_WIDTH = 16,
  parameter int CH_NUM     = 18,
  parameter int RELU_EN    = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clr,
  input  logic                         b_en,
  input  logic signed [BIAS_WIDTH-1:0] b_in,
  input  logic                         d_valid,
  output logic                         d_ready,
  input  logic signed [DATA_WIDTH-1:0] d_in,
  input  logic [4:0]                   d_ch,
  output logic                         q_valid,
  input  logic                         q_ready,
  output logic signed [DATA_WIDTH-1:0] q_data,
  output logic [4:0]                   q_ch,
  output logic                         bias_loaded,
  output logic                         ch_err
);

  typedef enum logic {
    ST_LOAD = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam logic [4:0] CH_LIM  = 5'(CH_NUM);
  localparam logic [4:0] CH_LAST = 5'(CH_NUM - 1);

  localparam logic signed [DATA_WIDTH-1:0] SAT_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [DATA_WIDTH-1:0] SAT_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  state_t                       state;
  logic [4:0]                   wr_idx;
  logic signed [BIAS_WIDTH-1:0] bias_tab [CH_NUM];

  logic                         load_wr;
  logic                         xfer;
  logic                         ch_ok;
  logic signed [BIAS_WIDTH-1:0] bias_sel;
  logic signed [DATA_WIDTH:0]   d_ext;
  logic signed [DATA_WIDTH:0]   b_ext;
  logic signed [DATA_WIDTH:0]   sum;
  logic signed [DATA_WIDTH-1:0] sat;
  logic signed [DATA_WIDTH-1:0] res;

  // Output stage may take a new word when empty or when it drains this cycle.
  assign d_ready = (state == ST_RUN) && (!q_valid || q_ready);
  assign xfer    = d_valid && d_ready;
  assign load_wr = (state == ST_LOAD) && b_en && !clr;

  // Bias table: plain storage, no reset; only read in RUN after a full load.
  always_ff @(posedge clk) begin
    if (load_wr) begin
      bias_tab[wr_idx] <= b_in;
    end
  end

  // Bias select, add at DATA_WIDTH+1 bits, saturate, optional ReLU.
  always_comb begin
    ch_ok    = (d_ch < CH_LIM);
    bias_sel = '0;
    if (ch_ok) begin
      bias_sel = bias_tab[d_ch];
    end
    d_ext = {d_in[DATA_WIDTH-1], d_in};
    b_ext = {{(DATA_WIDTH+1-BIAS_WIDTH){bias_sel[BIAS_WIDTH-1]}}, bias_sel};
    sum   = d_ext + b_ext;
    // Overflow shows up as disagreement between the two top bits.
    if (sum[DATA_WIDTH] != sum[DATA_WIDTH-1]) begin
      sat = sum[DATA_WIDTH] ? SAT_MIN : SAT_MAX;
    end else begin
      sat = sum[DATA_WIDTH-1:0];
    end
    res = sat;
    if ((RELU_EN != 0) && sat[DATA_WIDTH-1]) begin
      res = '0;
    end
  end

  // Control FSM and registered output stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_LOAD;
      wr_idx      <= '0;
      bias_loaded <= 1'b0;
      q_valid     <= 1'b0;
      q_data      <= '0;
      q_ch        <= '0;
      ch_err      <= 1'b0;
    end else if (clr) begin
      state       <= ST_LOAD;
      wr_idx      <= '0;
      bias_loaded <= 1'b0;
      q_valid     <= 1'b0;
      ch_err      <= 1'b0;
    end else begin
      case (state)
        ST_LOAD: begin
          if (b_en) begin
            wr_idx <= wr_idx + 5'd1;
            if (wr_idx == CH_LAST) begin
              state       <= ST_RUN;
              bias_loaded <= 1'b1;
            end
          end
        end
        ST_RUN: begin
        end
        default: begin
          state       <= ST_LOAD;
          bias_loaded <= 1'b0;
        end
      endcase

      if (xfer) begin
        q_valid <= 1'b1;
        q_data  <= res;
        q_ch    <= d_ch;
        if (!ch_ok) begin
          ch_err <= 1'b1;
        end
      end else if (q_ready) begin
        q_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_conv2_bias_add.sv
// Testbench for conv2_bias_add: one instance with ReLU, one without, sharing
// all inputs. A behavioural model (bias array, output slot, flags) predicts
// every output each cycle.
module tb_conv2_bias_add;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               clr = 1'b0;
  logic               b_en = 1'b0;
  logic signed [7:0]  b_in = '0;
  logic               d_valid = 1'b0;
  logic signed [15:0] d_in = '0;
  logic [4:0]         d_ch = '0;
  logic               q_ready = 1'b1;

  logic               d_ready, q_valid, bias_loaded, ch_err;
  logic signed [15:0] q_data;
  logic [4:0]         q_ch;
  logic               n_d_ready, n_q_valid, n_bias_loaded, n_ch_err;
  logic signed [15:0] n_q_data;
  logic [4:0]         n_q_ch;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  conv2_bias_add #(.BIAS_WIDTH(8), .DATA_WIDTH(16), .CH_NUM(18), .RELU_EN(1)) dut (
    .clk(clk), .rst(rst), .clr(clr), .b_en(b_en), .b_in(b_in),
    .d_valid(d_valid), .d_ready(d_ready), .d_in(d_in), .d_ch(d_ch),
    .q_valid(q_valid), .q_ready(q_ready), .q_data(q_data), .q_ch(q_ch),
    .bias_loaded(bias_loaded), .ch_err(ch_err)
  );

  conv2_bias_add #(.BIAS_WIDTH(8), .DATA_WIDTH(16), .CH_NUM(18), .RELU_EN(0)) dut_nr (
    .clk(clk), .rst(rst), .clr(clr), .b_en(b_en), .b_in(b_in),
    .d_valid(d_valid), .d_ready(n_d_ready), .d_in(d_in), .d_ch(d_ch),
    .q_valid(n_q_valid), .q_ready(q_ready), .q_data(n_q_data), .q_ch(n_q_ch),
    .bias_loaded(n_bias_loaded), .ch_err(n_ch_err)
  );

  // Reference model state
  int tab_m [18];
  int widx_m;
  bit loaded_m, qv_m, err_m;
  int qd_r, qd_n, qch_m;

  function automatic void chk(string name, logic signed [31:0] act, logic signed [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic int ref_q(int din, int ch, bit relu);
    int s;
    s = din + ((ch < 18) ? tab_m[ch] : 0);
    if (s > 32767) s = 32767;
    if (s < -32768) s = -32768;
    if (relu && s < 0) s = 0;
    return s;
  endfunction

  function automatic void model_reset();
    loaded_m = 0; widx_m = 0; qv_m = 0; err_m = 0;
    qd_r = 0; qd_n = 0; qch_m = 0;
  endfunction

  task automatic check_outs();
    chk("q_valid", q_valid, qv_m);
    chk("q_valid_nr", n_q_valid, qv_m);
    chk("bias_loaded", bias_loaded, loaded_m);
    chk("ch_err", ch_err, err_m);
    chk("ch_err_nr", n_ch_err, err_m);
    if (qv_m) begin
      chk("q_data", q_data, qd_r);
      chk("q_data_nr", n_q_data, qd_n);
      chk("q_ch", q_ch, qch_m);
    end
  endtask

  // One clock cycle with the currently driven inputs; model advances alongside.
  task automatic cyc();
    bit rdy;
    #1;
    rdy = loaded_m && (!qv_m || q_ready);
    chk("d_ready", d_ready, rdy);
    chk("d_ready_nr", n_d_ready, rdy);
    if (clr) begin
      loaded_m = 0; widx_m = 0; qv_m = 0; err_m = 0;
    end else begin
      if (!loaded_m && b_en) begin
        tab_m[widx_m] = b_in;
        widx_m++;
        if (widx_m == 18) loaded_m = 1;
      end
      if (rdy && d_valid) begin
        qv_m  = 1;
        qd_r  = ref_q(d_in, d_ch, 1);
        qd_n  = ref_q(d_in, d_ch, 0);
        qch_m = d_ch;
        if (d_ch >= 18) err_m = 1;
      end else if (q_ready) begin
        qv_m = 0;
      end
    end
    @(posedge clk);
    #1;
    check_outs();
  endtask

  task automatic idle();
    b_en = 0; d_valid = 0; clr = 0; q_ready = 1;
  endtask

  // Asynchronous reset: outputs must clear before any clock edge.
  task automatic do_reset();
    rst = 1;
    #1;
    model_reset();
    chk("rst_q_valid", q_valid, 0);
    chk("rst_q_data", q_data, 0);
    chk("rst_q_ch", q_ch, 0);
    chk("rst_bias_loaded", bias_loaded, 0);
    chk("rst_ch_err", ch_err, 0);
    chk("rst_d_ready", d_ready, 0);
    chk("rst_d_ready_nr", n_d_ready, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 0;
  endtask

  task automatic load_tab(input bit rnd);
    for (int k = 0; k < 18; k++) begin
      b_en = 1;
      b_in = rnd ? 8'($urandom) : 8'(k - 9);
      cyc();
    end
    b_en = 0;
    chk("loaded_after_18", bias_loaded, 1);
  endtask

  typedef struct {
    int din;
    int ch;
    int exp_r;
    int exp_n;
  } vec_t;

  vec_t vecs [9];

  initial begin
    vecs[0] = '{100,    3,  94,     94};
    vecs[1] = '{-50,    0,  0,      -59};
    vecs[2] = '{32760,  17, 32767,  32767};
    vecs[3] = '{-32768, 0,  0,      -32768};
    vecs[4] = '{32767,  0,  32758,  32758};
    vecs[5] = '{-32768, 17, 0,      -32760};
    vecs[6] = '{0,      9,  0,      0};
    vecs[7] = '{5,      4,  0,      0};
    vecs[8] = '{200,    12, 203,    203};

    idle();
    model_reset();
    #2;
    do_reset();

    // Load -9..8, then an extra strobe in RUN that must be ignored.
    load_tab(0);
    b_en = 1; b_in = 8'h7F; cyc(); b_en = 0;

    // Read the table back through the non-ReLU path.
    for (int c = 0; c < 18; c++) begin
      d_valid = 1; d_in = 16'(1000); d_ch = 5'(c);
      cyc();
      chk("readback", n_q_data, 1000 + c - 9);
    end
    d_valid = 0; cyc();

    // Directed datapath vectors
    for (int i = 0; i < 9; i++) begin
      d_valid = 1; q_ready = 1;
      d_in = 16'(vecs[i].din); d_ch = 5'(vecs[i].ch);
      cyc();
      d_valid = 0;
      chk("vec_relu", q_data, vecs[i].exp_r);
      chk("vec_norelu", n_q_data, vecs[i].exp_n);
      chk("vec_ch", q_ch, vecs[i].ch);
    end
    cyc();

    // Backpressure: hold, then stream without bubbles.
    d_valid = 1; d_in = 16'(111); d_ch = 5'd5; q_ready = 1;
    cyc();
    q_ready = 0; d_in = 16'(222);
    for (int j = 0; j < 3; j++) begin
      cyc();
      chk("bp_hold", q_data, 107);
      chk("bp_ready_low", d_ready, 0);
    end
    q_ready = 1;
    for (int j = 0; j < 4; j++) begin
      d_in = 16'(300 + j * 10); d_ch = 5'(j + 1);
      cyc();
      chk("bp_stream_valid", q_valid, 1);
      chk("bp_stream", q_data, 300 + j * 10 + j - 8);
    end
    d_valid = 0; cyc();
    chk("bp_drain", q_valid, 0);

    // Out-of-range channel
    d_valid = 1; d_in = 16'(1234); d_ch = 5'd20;
    cyc();
    d_valid = 0;
    chk("err_q_data", q_data, 1234);
    chk("err_q_data_nr", n_q_data, 1234);
    chk("err_flag", ch_err, 1);
    repeat (3) cyc();
    chk("err_sticky", ch_err, 1);

    // clr during a transfer and a bias strobe
    d_valid = 1; d_in = 16'(50); d_ch = 5'd2; clr = 1; b_en = 1; b_in = 8'sd55;
    cyc();
    idle();
    chk("clr_q_valid", q_valid, 0);
    chk("clr_ch_err", ch_err, 0);
    chk("clr_d_ready", d_ready, 0);
    chk("clr_loaded", bias_loaded, 0);
    load_tab(1);

    // Reset in the middle of a load
    clr = 1; cyc(); clr = 0;
    for (int k = 0; k < 7; k++) begin
      b_en = 1; b_in = 8'($urandom); cyc();
    end
    b_en = 0;
    do_reset();
    load_tab(1);

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      clr     = ($urandom_range(0, 299) == 0);
      b_en    = ($urandom_range(0, 1) == 1);
      b_in    = 8'($urandom);
      d_valid = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 3))
        0: d_in = 16'($urandom_range(0, 15) + 32752);
        1: d_in = 16'(-32768 + int'($urandom_range(0, 15)));
        default: d_in = 16'($urandom);
      endcase
      d_ch    = ($urandom_range(0, 15) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 17));
      q_ready = ($urandom_range(0, 2) != 0);
      cyc();
    end
    idle();
    cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/conv2_bias_add.md
CONV2_BIAS_ADD -- requirements
Module: conv2_bias_add

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- BIAS_WIDTH, 8, signed bias word width.
- DATA_WIDTH, 16, signed partial-sum and result width.
- CH_NUM, 18, number of output channels (bias entries).
- RELU_EN, 1, 1 = clamp negative results to 0.

REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clk, in, 1, single clock; all logic on rising edge.
- rst, in, 1, asynchronous active-high reset.
- clr, in, 1, synchronous clear; discards the bias table and re-enters load.
- b_en, in, 1, bias word strobe from the bias ROM reader.
- b_in, in, BIAS_WIDTH, bias word; channel 0 first, sequential order.
- d_valid, in, 1, partial sum present.
- d_ready, out, 1, block accepts the partial sum this cycle.
- d_in, in, DATA_WIDTH, signed convolution partial sum.
- d_ch, in, 5, channel index of d_in.
- q_valid, out, 1, result present.
- q_ready, in, 1, downstream accepts the result.
- q_data, out, DATA_WIDTH, biased, saturated, optionally rectified result.
- q_ch, out, 5, channel index of q_data.
- bias_loaded, out, 1, high while in RUN.
- ch_err, out, 1, sticky flag: an out-of-range d_ch was accepted.

Function
REQ-003 The block SHALL implement a two-state FSM, LOAD and RUN, entering LOAD on reset and on clr.
REQ-004 In LOAD, each cycle with b_en=1 SHALL write b_in to table[wr_idx] and increment wr_idx (5-bit, starting at 0).
REQ-005 The write that makes wr_idx reach CH_NUM SHALL move the FSM to RUN on the next edge, and bias_loaded SHALL then be 1.
REQ-006 In RUN, b_en SHALL be ignored; the table and wr_idx SHALL hold.
REQ-007 d_ready SHALL be 0 in LOAD. In RUN it SHALL equal (!q_valid || q_ready), combinationally.
REQ-008 A transfer SHALL occur when d_valid && d_ready; results appear registered exactly 1 cycle later, with q_valid=1 and q_ch=d_ch.
REQ-009 The sum SHALL be computed as d_in + sign-extended table[d_ch] at DATA_WIDTH+1 bits.
REQ-010 If the sum exceeds the signed DATA_WIDTH range, it SHALL saturate to 2^(DATA_WIDTH-1)-1 or -2^(DATA_WIDTH-1).
REQ-011 If RELU_EN=1 and the saturated value is negative, q_data SHALL be 0.
REQ-012 If an accepted d_ch >= CH_NUM, the bias used SHALL be 0 and ch_err SHALL set; ch_err is cleared only by rst or clr.
REQ-013 q_valid SHALL clear after an edge with q_ready=1 and no new transfer.
- With q_valid=1 and q_ready=0, q_data and q_ch SHALL hold unchanged.
- With q_valid=1, q_ready=1 and d_valid=1, the output SHALL reload back-to-back with no bubble (full throughput).
REQ-014 A cycle with clr=1 SHALL take priority over every other event.
- It SHALL force LOAD, wr_idx=0, q_valid=0 and ch_err=0 on that edge.
- Any simultaneous b_en or d transfer SHALL be discarded.
REQ-015 Table contents after clr are don't-care until rewritten; the block SHALL NOT use them because d_ready=0 in LOAD.

Reset
REQ-016 While rst=1, asynchronously: FSM=LOAD, wr_idx=0, q_valid=0, q_data=0, q_ch=0, bias_loaded=0, ch_err=0, and therefore d_ready=0.
REQ-017 Table registers SHALL NOT require reset.
REQ-018 Deasserting rst SHALL take effect on the first clk edge after release, with no further synchronisation inside the block.

Verification
REQ-019 Load: 18 b_en pulses with b_in=k-9 (k=0..17) -> bias_loaded=1 on the cycle after the 18th; the table reads back -9..8.
- A 19th b_en with value 0x7F -> table unchanged.
REQ-020 Datapath: d_in=100, d_ch=3 (bias -6), RELU_EN=1 -> next cycle q_data=94, q_ch=3.
- d_in=-50, d_ch=0 -> q_data=0.
REQ-021 Saturation: d_in=32760 with bias 8 -> q_data=32767.
- With RELU_EN=0, d_in=-32768 with bias -9 -> q_data=-32768.
REQ-022 Backpressure: q_ready=0 for 3 cycles with d_valid=1 -> d_ready=0 and q_data held.
- Then q_ready=1 for 4 cycles -> 4 consecutive results, no bubble, in order.
REQ-023 Error and clear: d_ch=20 accepted -> q_data=d_in (bias 0), ch_err=1 stays set.
- clr pulse during a d transfer -> q_valid=0, ch_err=0, d_ready=0, and the FSM is in LOAD.
REQ-024 Reset mid-load: rst asserted after 7 b_en -> all outputs zero immediately.
- After release, 18 new b_en are required before bias_loaded=1.
